// File: rtl/rx_word_deserialiser.sv
// Rx bit-stream to word deserialiser: packs decoded bits into DATA_WIDTH-bit words,
// reports partial-word bit counts and, optionally, ISO 14443A odd-parity failures.
module rx_word_deserialiser #(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_soc,
  input  logic                          in_eoc,
  input  logic                          in_data,
  input  logic                          in_data_valid,
  input  logic                          in_error,
  output logic                          out_soc,
  output logic                          out_eoc,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_data_valid,
  output logic [$clog2(DATA_WIDTH)-1:0] out_data_bits,
  output logic                          out_parity_err,
  output logic                          out_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [DATA_WIDTH-1:0]   shreg, shreg_d;
  logic                    eoc_pend, eoc_pend_d;

  logic                    soc_d, eoc_d, dv_d, perr_d, err_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic [CNT_W-1:0]        bits_d;

  // Word position of the bit arriving while cnt bits are already stored.
  function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] c);
    if (MSB_FIRST) return LAST - c;
    return c;
  endfunction

  // Odd parity over word plus parity bit: failure when the number of ones is even.
  function automatic logic parity_fail(input logic [DATA_WIDTH-1:0] w, input logic p);
    return ~(^{w, p});
  endfunction

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    shreg_d    = shreg;
    eoc_pend_d = 1'b0;
    soc_d      = 1'b0;
    eoc_d      = eoc_pend;
    dv_d       = 1'b0;
    err_d      = 1'b0;
    data_d     = out_data;
    bits_d     = out_data_bits;
    perr_d     = out_parity_err;

    if (in_soc) begin
      soc_d   = 1'b1;
      shreg_d = '0;
      cnt_d   = '0;
      state_d = DATA;
    end else if (state != IDLE) begin
      if (in_error) begin
        // Partial word is dropped; an eoc arriving with the error is still reported.
        err_d   = 1'b1;
        eoc_d   = in_eoc;
        state_d = IDLE;
      end else if (in_eoc) begin
        state_d = IDLE;
        if (state == PARITY) begin
          // Parity bit never came: flush the word as failed, eoc follows next cycle.
          dv_d       = 1'b1;
          data_d     = shreg;
          bits_d     = '0;
          perr_d     = 1'b1;
          eoc_pend_d = 1'b1;
        end else if (cnt != '0) begin
          dv_d   = 1'b1;
          eoc_d  = 1'b1;
          data_d = shreg;
          bits_d = cnt;
          perr_d = 1'b0;
        end else begin
          eoc_d = 1'b1;
        end
      end else if (in_data_valid) begin
        if (state == PARITY) begin
          dv_d    = 1'b1;
          data_d  = shreg;
          bits_d  = '0;
          perr_d  = parity_fail(shreg, in_data);
          shreg_d = '0;
          state_d = DATA;
        end else begin
          shreg_d[bit_pos(cnt)] = in_data;
          cnt_d = (cnt == LAST) ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            if (PARITY_EN) begin
              state_d = PARITY;
            end else begin
              dv_d    = 1'b1;
              data_d  = shreg_d;
              bits_d  = '0;
              perr_d  = 1'b0;
              shreg_d = '0;
            end
          end
        end
      end
    end
  end

  // Registered control and output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      eoc_pend       <= 1'b0;
      out_soc        <= 1'b0;
      out_eoc        <= 1'b0;
      out_data_valid <= 1'b0;
      out_error      <= 1'b0;
      out_data       <= '0;
      out_data_bits  <= '0;
      out_parity_err <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      eoc_pend       <= eoc_pend_d;
      out_soc        <= soc_d;
      out_eoc        <= eoc_d;
      out_data_valid <= dv_d;
      out_error      <= err_d;
      out_data       <= data_d;
      out_data_bits  <= bits_d;
      out_parity_err <= perr_d;
    end
  end

  // Assembly register: always rebuilt from zero after soc, so it needs no reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_d;
  end

endmodule

// File: tb/tb_rx_word_deserialiser.sv
// Scoreboard bench: two deserialiser configurations share one randomized Rx bit stream;
// a frame-level reference model predicts every output event and its cycle.
module tb_rx_word_deserialiser;

  typedef struct packed {bit soc; bit eoc; bit dv; bit d; bit err; bit rst;} stim_t;
  typedef struct {
    int cyc; bit soc; bit eoc; bit dv; bit err; bit perr; logic [31:0] data; int bits;
  } ev_t;

  logic clk, rst;
  logic in_soc, in_eoc, in_data, in_data_valid, in_error;

  logic       a_soc, a_eoc, a_dv, a_perr, a_err;
  logic [7:0] a_data;
  logic [2:0] a_bits;
  logic        b_soc, b_eoc, b_dv, b_perr, b_err;
  logic [15:0] b_data;
  logic [3:0]  b_bits;

  rx_word_deserialiser #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_soc(in_soc), .in_eoc(in_eoc), .in_data(in_data),
    .in_data_valid(in_data_valid), .in_error(in_error),
    .out_soc(a_soc), .out_eoc(a_eoc), .out_data(a_data), .out_data_valid(a_dv),
    .out_data_bits(a_bits), .out_parity_err(a_perr), .out_error(a_err));

  rx_word_deserialiser #(.DATA_WIDTH(16), .PARITY_EN(1'b0), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_soc(in_soc), .in_eoc(in_eoc), .in_data(in_data),
    .in_data_valid(in_data_valid), .in_error(in_error),
    .out_soc(b_soc), .out_eoc(b_eoc), .out_data(b_data), .out_data_valid(b_dv),
    .out_data_bits(b_bits), .out_parity_err(b_perr), .out_error(b_err));

  stim_t plan[$];
  ev_t   q0[$], q1[$];
  bit    mfb[$];
  int    mfc[$];
  int    tests = 0, fails = 0;
  int    cyc = 0, start_cyc = 0;
  bit    rst_seen = 1'b0;
  logic [31:0] last_data [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // ---------------- stimulus plan ----------------
  task automatic add(input bit soc, input bit eoc, input bit dv, input bit d, input bit err, input bit r);
    stim_t s;
    s.soc = soc; s.eoc = eoc; s.dv = dv; s.d = d; s.err = err; s.rst = r;
    plan.push_back(s);
  endtask

  task automatic add_idle(input int n, input bit noise);
    for (int k = 0; k < n; k++)
      if (noise) add(0, 0, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 0);
      else add(0, 0, 0, 0, 0, 0);
  endtask

  task automatic add_bits(input logic [31:0] v, input int n, input bit msb);
    logic [31:0] t;
    t = v;
    for (int b = 0; b < n; b++) add(0, 0, 1, msb ? t[n-1-b] : t[b], 0, 0);
  endtask

  // ---------------- reference model ----------------
  function automatic ev_t mk(input int c, input bit soc, input bit eoc, input bit dv, input bit err,
                             input bit perr, input logic [31:0] data, input int bits);
    ev_t e;
    e.cyc = c; e.soc = soc; e.eoc = eoc; e.dv = dv; e.err = err; e.perr = perr;
    e.data = data; e.bits = bits;
    return e;
  endfunction

  task automatic push(input int which, input ev_t e);
    if (which == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  function automatic logic [31:0] word_of(input int W, input bit msb, input int base, input int n);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < n; b++) if (mfb[base+b]) w[msb ? W-1-b : b] = 1'b1;
    return w;
  endfunction

  // Every complete word (plus parity bit when enabled) comes out one cycle after its last bit.
  task automatic emit_full(input int W, input bit par, input bit msb, input int which,
                           output int base, output int rem);
    int c, nfull, ones;
    bit pf;
    c = W + int'(par);
    nfull = mfb.size() / c;
    for (int k = 0; k < nfull; k++) begin
      ones = 0;
      for (int b = 0; b < W; b++) ones += int'(mfb[k*c+b]);
      pf = par ? (((ones + int'(mfb[k*c+W])) % 2) == 0) : 1'b0;
      push(which, mk(mfc[k*c+c-1] + 1, 0, 0, 1, 0, pf, word_of(W, msb, k*c, W), 0));
    end
    base = nfull * c;
    rem  = mfb.size() - base;
  endtask

  task automatic run_model(input int W, input bit par, input bit msb, input int which);
    bit in_frame;
    int base, rem;
    in_frame = 0;
    mfb.delete(); mfc.delete();
    for (int i = 0; i < plan.size(); i++) begin
      if (plan[i].rst) begin
        if (in_frame) emit_full(W, par, msb, which, base, rem);
        in_frame = 0; mfb.delete(); mfc.delete();
      end else if (plan[i].soc) begin
        if (in_frame) emit_full(W, par, msb, which, base, rem);
        mfb.delete(); mfc.delete();
        push(which, mk(i + 1, 1, 0, 0, 0, 0, 0, 0));
        in_frame = 1;
      end else if (in_frame) begin
        if (plan[i].err) begin
          emit_full(W, par, msb, which, base, rem);
          push(which, mk(i + 1, 0, plan[i].eoc, 0, 1, 0, 0, 0));
          in_frame = 0; mfb.delete(); mfc.delete();
        end else if (plan[i].eoc) begin
          emit_full(W, par, msb, which, base, rem);
          if (rem == 0) push(which, mk(i + 1, 0, 1, 0, 0, 0, 0, 0));
          else if (rem < W) push(which, mk(i + 1, 0, 1, 1, 0, 0, word_of(W, msb, base, rem), rem));
          else begin
            push(which, mk(i + 1, 0, 0, 1, 0, 1, word_of(W, msb, base, W), 0));
            push(which, mk(i + 2, 0, 1, 0, 0, 0, 0, 0));
          end
          in_frame = 0; mfb.delete(); mfc.delete();
        end else if (plan[i].dv) begin
          mfb.push_back(plan[i].d);
          mfc.push_back(i);
        end
      end
    end
    if (in_frame) emit_full(W, par, msb, which, base, rem);
  endtask

  // ---------------- monitor ----------------
  task automatic check_out(input int which, input logic soc, input logic eoc, input logic dv,
                           input logic err, input logic perr, input logic [31:0] data, input int bits);
    ev_t e;
    bit have;
    int rc;
    string nm;
    nm = (which == 0) ? "w8_par_lsb" : "w16_msb";
    rc = cyc - start_cyc;
    if (rst_seen) begin
      tests++;
      if ({soc, eoc, dv, err, perr} !== 5'b0 || data !== 32'd0 || bits != 0) begin
        fails++;
        $display("FAIL %s reset_state: soc/eoc/dv/err/perr=%b%b%b%b%b data=%h bits=%0d, required all zero",
                 nm, soc, eoc, dv, err, perr, data, bits);
      end
      last_data[which] = '0;
    end else if ((soc | eoc | dv | err) === 1'b1) begin
      tests++;
      have = 0;
      if (which == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      if (which == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      if (!have) begin
        fails++;
        $display("FAIL %s unexpected_event: cycle %0d soc/eoc/dv/err=%b%b%b%b data=%h, required no event",
                 nm, rc, soc, eoc, dv, err, data);
      end else if (rc != e.cyc || soc !== e.soc || eoc !== e.eoc || dv !== e.dv || err !== e.err ||
                   (e.dv && (data !== e.data || bits != e.bits || perr !== e.perr)) ||
                   (!e.dv && data !== last_data[which])) begin
        fails++;
        $display("FAIL %s event: got cyc=%0d soc/eoc/dv/err=%b%b%b%b data=%h bits=%0d perr=%b, required cyc=%0d soc/eoc/dv/err=%b%b%b%b data=%h bits=%0d perr=%b",
                 nm, rc, soc, eoc, dv, err, data, bits, perr,
                 e.cyc, e.soc, e.eoc, e.dv, e.err, e.dv ? e.data : last_data[which], e.bits, e.perr);
      end
      if (dv === 1'b1) last_data[which] = data;
    end else begin
      tests++;
      if (data !== last_data[which]) begin
        fails++;
        $display("FAIL %s data_hold: cycle %0d data=%h, required %h", nm, rc, data, last_data[which]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      check_out(0, a_soc, a_eoc, a_dv, a_err, a_perr, 32'(a_data), int'(a_bits));
      check_out(1, b_soc, b_eoc, b_dv, b_err, b_perr, 32'(b_data), int'(b_bits));
    end
  end

  // ---------------- main ----------------
  initial begin
    int last_eoc, r, nbits;
    bit restart;
    rst = 1'b1; in_soc = 0; in_eoc = 0; in_data = 0; in_data_valid = 0; in_error = 0;
    last_data[0] = '0; last_data[1] = '0;

    // Directed frames.
    add_idle(3, 0);
    add(1, 0, 0, 0, 0, 0); add_bits(32'hA5, 8, 0); add(0, 0, 1, 1, 0, 0); add(0, 1, 0, 0, 0, 0);
    add_idle(4, 0);
    add(1, 0, 0, 0, 0, 0); add_bits(32'hA5, 8, 0); add(0, 0, 1, 0, 0, 0); add(0, 1, 0, 0, 0, 0);
    add_idle(4, 0);
    add(1, 0, 0, 0, 0, 0); add_bits(32'b011, 3, 0); add(0, 1, 0, 0, 0, 0);
    add_idle(4, 0);
    add(1, 0, 0, 0, 0, 0); add_bits(32'h0F, 8, 0); add(0, 1, 0, 0, 0, 0);
    add_idle(4, 0);
    add(1, 0, 0, 0, 0, 0); add_bits(32'h1234, 16, 1); add_idle(2, 0); add(0, 1, 0, 0, 0, 0);
    add_idle(4, 0);
    add(1, 0, 0, 0, 0, 0); add_bits(32'h15, 5, 0); add(0, 0, 0, 0, 1, 0);
    add_bits(32'h3C, 8, 0); add(0, 1, 0, 0, 0, 0); add_idle(4, 1);
    add(1, 0, 0, 0, 0, 0); add_bits(32'h5, 3, 0); add(0, 0, 0, 0, 0, 1); add_idle(3, 0);
    add(1, 0, 0, 0, 0, 0); add_bits(32'h5A, 8, 0); add(0, 0, 1, 1, 0, 0); add(0, 1, 0, 0, 0, 0);

    // Randomized frames with gaps, idle noise and every way a frame can end.
    restart = 0;
    for (int f = 0; f < 60; f++) begin
      if (!restart) add_idle($urandom_range(3, 6), 1);
      add(1, 0, 0, 0, 0, 0);
      nbits = $urandom_range(0, 40);
      for (int b = 0; b < nbits; b++) begin
        repeat ($urandom_range(0, 2)) add(0, 0, 0, 1'($urandom), 0, 0);
        add(0, 0, 1, 1'($urandom), 0, 0);
      end
      r = $urandom_range(0, 19);
      restart = (r == 18);
      if (r <= 13) add(0, 1, 0, 0, 0, 0);
      else if (r <= 15) add(0, 0, 1'($urandom), 1'($urandom), 1, 0);
      else if (r == 16) add(0, 1, 0, 0, 1, 0);
      else if (r == 17) add(0, 0, 0, 0, 0, 1);
    end
    add_idle(6, 0);

    run_model(8, 1'b1, 1'b0, 0);
    run_model(16, 1'b0, 1'b1, 1);

    repeat (3) @(posedge clk);
    last_eoc = -100;
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) start_cyc = cyc;
      if (plan[i].soc)
        assert (i - last_eoc >= 2) else $error("soc issued %0d cycles after eoc", i - last_eoc);
      if (plan[i].eoc) last_eoc = i;
      rst = plan[i].rst; in_soc = plan[i].soc; in_eoc = plan[i].eoc;
      in_data_valid = plan[i].dv; in_data = plan[i].d; in_error = plan[i].err;
    end
    repeat (4) @(posedge clk);
    @(negedge clk); #1;

    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL w8_par_lsb missing_events: %0d left, required 0", q0.size());
    end
    tests++;
    if (q1.size() != 0) begin
      fails++;
      $display("FAIL w16_msb missing_events: %0d left, required 0", q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_word_deserialiser.md
Name: rx_word_deserialiser

Overview:
- Parametrised successor to the bit-level Rx interface stage.
- Converts the bit-by-bit Rx stream (soc/eoc/data/data_valid/error) into DATA_WIDTH-bit words with a partial-word bit count.
- Optionally checks the ISO 14443A odd-parity bit that follows each full word, and supports either bit order.
- Sits between the Rx decoder and the frame handler; its output obeys the by-word Rx interface rules.

Parameters:
DATA_WIDTH, 8, word width in bits; legal values 2, 4, 8, 16, 32.
PARITY_EN, 1, 1: a parity bit follows every full word and is checked for odd parity; 0: no parity bits.
MSB_FIRST, 0, 0: first received bit goes to out_data[0]; 1: first received bit goes to out_data[DATA_WIDTH-1].

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_soc  input  1  start of communication pulse
in_eoc  input  1  end of communication pulse
in_data  input  1  received bit
in_data_valid  input  1  in_data valid this cycle
in_error  input  1  decoder error pulse
out_soc  output  1  start of communication pulse
out_eoc  output  1  end of communication pulse
out_data  output  DATA_WIDTH  assembled word
out_data_valid  output  1  out_data valid this cycle
out_data_bits  output  $clog2(DATA_WIDTH)  valid bits in out_data; 0 means a full word
out_parity_err  output  1  parity failure for the word; qualified by out_data_valid
out_error  output  1  error pulse

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered. Every output event appears exactly 1 cycle after the causing input.
- Reset (rst=1 at a clk edge, including mid-frame): all pulses 0, out_data=0, out_data_bits=0, out_parity_err=0, state IDLE, bit counter 0, pending-eoc flag clear.
- States:
  - IDLE: only in_soc is acted on; data_valid, eoc and error are ignored.
  - DATA: collecting word bits.
  - PARITY: full word held, awaiting its parity bit (only when PARITY_EN=1).
- in_soc, in any state: out_soc pulse; clear shift register and counter; go to DATA.
- DATA with in_data_valid:
  - Store the bit at position cnt (LSB first), or at DATA_WIDTH-1-cnt when MSB_FIRST=1; then cnt++.
  - On the last bit (cnt==DATA_WIDTH-1), cnt wraps to 0.
  - PARITY_EN=0: emit out_data_valid with out_data_bits=0 and out_parity_err=0.
  - PARITY_EN=1: go to PARITY and hold the word.
- PARITY with in_data_valid:
  - Emit the word with out_data_valid and out_data_bits=0.
  - out_parity_err = ~(^{word,bit}), i.e. set when the total count of ones is even.
  - Return to DATA.
- in_eoc in DATA:
  - cnt>0: out_data_valid and out_eoc in the same cycle, out_data_bits=cnt, unfilled bits 0, out_parity_err=0.
  - cnt==0: out_eoc only.
  - Then go to IDLE.
- in_eoc in PARITY (parity bit missing):
  - Cycle 1: out_data_valid with the word, out_data_bits=0, out_parity_err=1.
  - Cycle 2: out_eoc, driven from the pending-eoc flag.
  - Then IDLE.
- in_error in DATA/PARITY: out_error pulse; partial word discarded, no out_data_valid; go to IDLE. If in_eoc is high in the same cycle, out_error and out_eoc pulse together.
- Simultaneous inputs: in_error dominates in_data_valid.
- Input precondition: at least 2 cycles between in_eoc and the next in_soc. The bench asserts this.
- Output invariants:
  - Each flag is high for one cycle only.
  - out_soc is exclusive with all other flags.
  - out_eoc may accompany out_data_valid only with out_data_bits!=0.
  - out_error never accompanies out_data_valid or out_soc.
  - out_data holds its value when out_data_valid=0.

Test Plan:
- W=8, PAR=1, LSB first: soc, bits 1,0,1,0,0,1,0,1, parity 1, eoc -> out_data=0xA5, out_data_bits=0, out_parity_err=0; next event is a lone out_eoc.
- Same frame with parity bit 0 -> out_data=0xA5, out_parity_err=1.
- W=8, PAR=1: soc, bits 1,1,0, eoc -> out_data=0x03, out_data_bits=3, out_data_valid and out_eoc in the same cycle.
- W=8, PAR=1: soc, 8 bits of 0x0F, eoc with no parity bit -> out_data_valid with 0x0F, out_parity_err=1, out_data_bits=0; out_eoc 1 cycle later.
- W=16, PAR=0, MSB_FIRST=1: soc, 16 bits of 0x1234 MSB first -> out_data=0x1234 and out_data_bits=0, exactly 1 cycle after the 16th bit.
- Error and reset: soc, 5 bits, in_error -> out_error only, with later bits ignored until soc. Separately, rst mid-word -> all outputs 0 next cycle, and a fresh soc/byte then decodes correctly.
